// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command front end for a registered 8-bit ALU.
// Screens illegal commands, drives the ALU operands, waits out the ALU latency,
// then returns the tagged result with an error flag and a self-check mismatch flag.
module alu_cmd_driver #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_mismatch,
  output logic [15:0]      txn_count
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_expected;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [3:0]         r_alu_sel;
  logic               r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_rsp_err;
  logic               r_rsp_mismatch;
  logic [15:0]        r_txn_count;

  logic               w_legal;
  logic               w_div_zero;
  logic [7:0]         w_expected;

  // Command classification: ops 0..3 are legal except divide by zero
  assign w_div_zero = (cmd_op == 4'd3) && (cmd_b == 8'd0);
  assign w_legal    = (cmd_op <= 4'd3) && !w_div_zero;

  // Reference result the ALU output is checked against
  always_comb begin
    w_expected = 8'd0;
    case (cmd_op)
      4'd0:    w_expected = cmd_a + cmd_b;
      4'd1:    w_expected = cmd_a - cmd_b;
      4'd2:    w_expected = cmd_a * cmd_b;
      4'd3:    w_expected = (cmd_b != 8'd0) ? (cmd_a / cmd_b) : 8'hFF;
      default: w_expected = 8'd0;
    endcase
  end

  // Control FSM with all outputs and the datapath registered
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_expected     <= 8'd0;
      r_alu_a        <= 8'd0;
      r_alu_b        <= 8'd0;
      r_alu_sel      <= 4'd0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= 8'd0;
      r_rsp_tag      <= '0;
      r_rsp_err      <= 1'b0;
      r_rsp_mismatch <= 1'b0;
      r_txn_count    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_rsp_tag <= cmd_tag;
            if (w_legal) begin
              r_alu_a    <= cmd_a;
              r_alu_b    <= cmd_b;
              r_alu_sel  <= cmd_op;
              r_expected <= w_expected;
              r_cnt      <= CNT_W'(ALU_LAT);
              r_state    <= S_WAIT;
            end else begin
              // ALU untouched; answer immediately with a fixed error code
              r_rsp_err      <= 1'b1;
              r_rsp_data     <= w_div_zero ? 8'hFF : 8'h00;
              r_rsp_mismatch <= 1'b0;
              r_rsp_valid    <= 1'b1;
              r_state        <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data     <= alu_out;
            r_rsp_mismatch <= (alu_out != r_expected);
            r_rsp_err      <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_txn_count <= r_txn_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_sel      = r_alu_sel;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_err      = r_rsp_err;
  assign rsp_mismatch = r_rsp_mismatch;
  assign txn_count    = r_txn_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural pipelined ALU model.
module tb_alu_cmd_driver;

  localparam int unsigned ALU_LAT = 3;
  localparam int unsigned TAG_W   = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             rsp_mismatch;
  logic [15:0]      txn_count;

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             mism;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_txn  = 16'd0;
  logic [7:0]  last_a   = 8'd0;
  logic [7:0]  last_b   = 8'd0;
  logic [3:0]  last_sel = 4'd0;
  bit          corrupt  = 1'b0;
  bit          rand_rdy = 1'b0;

  alu_cmd_driver #(.ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .txn_count(txn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic meaning of each opcode on unsigned 8-bit operands
  function automatic logic [7:0] model_res(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 256;
      1:       r = (a - b + 256) % 256;
      2:       r = (a * b) % 256;
      3:       r = (b == 0) ? 255 : a / b;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // ALU stand-in: result appears ALU_LAT edges after its inputs are registered
  logic [7:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= model_res(int'(alu_a), int'(alu_b), int'(alu_sel));
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out = corrupt ? 8'h00 : alu_pipe[ALU_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got tag %0h with empty scoreboard", rsp_tag);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mism));
        end
        exp_txn = exp_txn + 16'd1;
      end
    end
  end

  // Random backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command; optionally score it and check response latency
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input bit track);
    bit   legal;
    bit   ok;
    int   lat;
    exp_t e;
    logic [7:0] r;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got cmd_ready 0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    legal = (int'(op) <= 3) && !(int'(op) == 3 && b == 8'd0);
    r = model_res(int'(a), int'(b), int'(op));
    if (legal) begin last_a = a; last_b = b; last_sel = op; end
    e.data = legal ? (corrupt ? 8'h00 : r) : ((int'(op) == 3) ? 8'hFF : 8'h00);
    e.tag  = tag;
    e.err  = !legal;
    e.mism = legal && corrupt && (r != 8'h00);
    if (track) sb_q.push_back(e);
    chk("alu_a", 32'(alu_a), 32'(last_a));
    chk("alu_b", 32'(alu_b), 32'(last_b));
    chk("alu_sel", 32'(alu_sel), 32'(last_sel));
    if (track) begin
      lat = 99;
      for (int k = 1; k <= 40; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        else if (!rsp_valid) begin @(posedge clk); #1; end
        if (rsp_valid) begin lat = k; break; end
      end
      chk("rsp_latency", 32'(lat), legal ? 32'(ALU_LAT + 1) : 32'd1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (cmd_ready && !rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got cmd_ready %0b expected 1", cmd_ready);
    end
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
  endtask

  initial begin
    logic [15:0] t0;
    int          seen;
    reset = 1'b1; cmd_valid = 1'b1; cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = 4'd0;
    cmd_tag = '0; rsp_ready = 1'b1;

    // Reset held 3 cycles with a pending command
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    reset = 1'b0; cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_no_accept", 32'(rsp_valid), 32'd0);

    // Add with wrap-around
    send(8'd200, 8'd100, 4'd0, 4'd3, 1'b1);
    wait_idle();
    chk("txn_after_add", 32'(txn_count), 32'd1);

    // Illegal commands leave the ALU inputs alone
    send(8'd100, 8'd0, 4'd3, 4'd4, 1'b1);
    wait_idle();
    send(8'd33, 8'd44, 4'd9, 4'd5, 1'b1);
    wait_idle();

    // Backpressure: response held stable while rsp_ready is low
    rsp_ready = 1'b0;
    t0 = exp_txn;
    send(8'd16, 8'd17, 4'd2, 4'd6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_data", 32'(rsp_data), 32'h10);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_txn_count", 32'(txn_count), 32'(t0));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_txn_once", 32'(txn_count), 32'(t0 + 16'd1));

    // Corrupted ALU output flags a mismatch
    corrupt = 1'b1;
    send(8'd5, 8'd7, 4'd1, 4'd8, 1'b1);
    wait_idle();
    corrupt = 1'b0;

    // Reset while waiting on the ALU abandons the transaction
    send(8'd10, 8'd20, 4'd0, 4'd7, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_txn = 16'd0; last_a = 8'd0; last_b = 8'd0; last_sel = 4'd0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_txn_count", 32'(txn_count), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomised traffic with random backpressure and occasional ALU corruption
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      corrupt = ($urandom_range(0, 7) == 0);
      send(a, b, op, 4'($urandom), 1'b1);
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    corrupt = 1'b0;

    // txn_count wrap: preload near the top, then complete four responses
    @(negedge clk);
    force dut.r_txn_count = 16'hFFFD;
    exp_txn = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.r_txn_count;
    for (int i = 0; i < 4; i++) begin
      send(8'd1, 8'd2, 4'd12, 4'(i), 1'b1);
      wait_idle();
      if (i == 2) chk("txn_wrap_zero", 32'(txn_count), 32'd0);
    end
    chk("txn_after_wrap", 32'(txn_count), 32'd1);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
